// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_if
// Description : Bundles the two bus faces of the instruction cache.
//               Fetch lookup side:  if_rd_en, if_rd_addr -> if_hit, if_hit_inst
//               Memory refill side: mem_rd_req, mem_rd_addr -> mem_rd_done,
//                                   mem_rd_data
//               slave  : cache view (answers lookups, issues refill reads)
//               master : environment view (fetcher + memory controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_if;
    // Fetcher lookup
    logic        if_rd_en;
    logic [31:0] if_rd_addr;
    logic        if_hit;
    logic [31:0] if_hit_inst;
    // Memory controller refill port
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_done;
    logic [31:0] mem_rd_data;

    modport slave (
        input  if_rd_en,
        input  if_rd_addr,
        output if_hit,
        output if_hit_inst,
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_done,
        input  mem_rd_data
    );

    modport master (
        output if_rd_en,
        output if_rd_addr,
        input  if_hit,
        input  if_hit_inst,
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_done,
        output mem_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, read-only instruction cache. Hits are served
//               combinationally; a miss refills the whole line one word at a
//               time through a req/done handshake with the memory controller.
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               rdy  - global ready, low freezes all state
//               bus  - icache_if.slave (fetch lookup + memory refill port)
// Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int INDEX_BITS     = 6,
    parameter int LINE_WORDS_LOG = 2
) (
    input wire       clk,
    input wire       rst,
    input wire       rdy,
    icache_if.slave  bus
);

    localparam int c_OFF_BITS = 2 + LINE_WORDS_LOG;
    localparam int c_TAG_BITS = 32 - INDEX_BITS - c_OFF_BITS;
    localparam int c_LINES    = 1 << INDEX_BITS;
    localparam int c_WORDS    = 1 << LINE_WORDS_LOG;
    localparam logic [LINE_WORDS_LOG-1:0] c_LAST_WORD = {LINE_WORDS_LOG{1'b1}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage: only the valid bits are reset.
    logic [c_LINES-1:0]    r_valid;
    logic [c_TAG_BITS-1:0] r_tag  [c_LINES];
    logic [31:0]           r_data [c_LINES*c_WORDS];

    logic                      r_mem_rd_req;
    logic [31:0]               r_mem_rd_addr;
    logic [LINE_WORDS_LOG-1:0] r_cnt;

    logic                      w_req_nxt;
    logic [31:0]               w_addr_nxt;
    logic [LINE_WORDS_LOG-1:0] w_cnt_nxt;
    logic                      w_line_start;
    logic                      w_data_we;
    logic                      w_line_done;

    // Lookup address fields
    logic [INDEX_BITS-1:0]     w_idx;
    logic [LINE_WORDS_LOG-1:0] w_word;
    logic [c_TAG_BITS-1:0]     w_tag;
    logic                      w_match;
    logic [1:0]                w_unused;

    // The line being filled is identified by the outstanding request
    // address; its index/tag bits never change during a refill.
    logic [INDEX_BITS-1:0]     w_fill_idx;
    logic [c_TAG_BITS-1:0]     w_fill_tag;

    assign w_idx      = bus.if_rd_addr[c_OFF_BITS +: INDEX_BITS];
    assign w_word     = bus.if_rd_addr[2 +: LINE_WORDS_LOG];
    assign w_tag      = bus.if_rd_addr[31 -: c_TAG_BITS];
    assign w_unused   = bus.if_rd_addr[1:0];
    assign w_fill_idx = r_mem_rd_addr[c_OFF_BITS +: INDEX_BITS];
    assign w_fill_tag = r_mem_rd_addr[31 -: c_TAG_BITS];

    assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign bus.if_hit      = !rst && rdy && bus.if_rd_en && (r_state == IDLE) && w_match;
    assign bus.if_hit_inst = r_data[{w_idx, w_word}];
    assign bus.mem_rd_req  = r_mem_rd_req;
    assign bus.mem_rd_addr = r_mem_rd_addr;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_mem_rd_req;
        w_addr_nxt   = r_mem_rd_addr;
        w_cnt_nxt    = r_cnt;
        w_line_start = 1'b0;
        w_data_we    = 1'b0;
        w_line_done  = 1'b0;

        if (!rst && rdy) begin
            case (r_state)
                IDLE: begin
                    if (bus.if_rd_en && !w_match) begin
                        w_line_start = 1'b1;
                        w_state_nxt  = REFILL;
                        w_req_nxt    = 1'b1;
                        w_addr_nxt   = {bus.if_rd_addr[31:c_OFF_BITS], {c_OFF_BITS{1'b0}}};
                        w_cnt_nxt    = '0;
                    end
                end
                REFILL: begin
                    if (bus.mem_rd_done) begin
                        w_data_we = 1'b1;
                        if (r_cnt == c_LAST_WORD) begin
                            w_line_done = 1'b1;
                            w_req_nxt   = 1'b0;
                            w_state_nxt = IDLE;
                        end else begin
                            // Next word requested back-to-back, no bubble.
                            w_cnt_nxt  = LINE_WORDS_LOG'(r_cnt + 1'b1);
                            w_addr_nxt = r_mem_rd_addr + 32'd4;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request registers and valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rd_req  <= 1'b0;
            r_mem_rd_addr <= '0;
            r_cnt         <= '0;
            r_valid       <= '0;
        end else begin
            r_mem_rd_req  <= w_req_nxt;
            r_mem_rd_addr <= w_addr_nxt;
            r_cnt         <= w_cnt_nxt;
            // Victim is invalidated up front so a partially overwritten
            // line can never produce a hit.
            if (w_line_start) begin
                r_valid[w_idx] <= 1'b0;
            end
            if (w_line_done) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_data_we) begin
            r_data[{w_fill_idx, r_cnt}] <= bus.mem_rd_data;
        end
        if (w_line_done) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache: reset state, cold miss refill,
//               table of lookups on a filled line, conflict replacement,
//               reset during refill, rdy stall during refill, stray done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache #(
        .INDEX_BITS     (6),
        .LINE_WORDS_LOG (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] line_words [4];

    typedef struct {
        logic        rdy;
        logic        en;
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_inst;
        logic        exp_req;
    } vec_t;

    vec_t vecs [8];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a lookup for the current cycle and check the hit result.
    task automatic lookup(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_inst);
        bus.if_rd_en   = 1'b1;
        bus.if_rd_addr = a;
        #1;
        check("lookup_hit", {31'b0, bus.if_hit}, {31'b0, exp_hit});
        if (exp_hit) begin
            check("lookup_inst", bus.if_hit_inst, exp_inst);
        end
    endtask

    // Called in the cycle a miss is presented. Serves line_words with the
    // given per-word latency and probes 'probe' for hits throughout.
    task automatic refill(input logic [31:0] base, input int lat, input logic [31:0] probe);
        cyc();
        bus.if_rd_en   = 1'b1;
        bus.if_rd_addr = probe;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < lat - 1; l++) begin
                #1;
                check("req_hold", {31'b0, bus.mem_rd_req}, 32'd1);
                check("addr_hold", bus.mem_rd_addr, base + 32'(4 * k));
                check("hit_in_refill", {31'b0, bus.if_hit}, 32'd0);
                cyc();
            end
            bus.mem_rd_done = 1'b1;
            bus.mem_rd_data = line_words[k];
            #1;
            check("req_at_done", {31'b0, bus.mem_rd_req}, 32'd1);
            check("addr_at_done", bus.mem_rd_addr, base + 32'(4 * k));
            cyc();
            bus.mem_rd_done = 1'b0;
            bus.mem_rd_data = 32'hDEAD_BEEF;
        end
        bus.if_rd_en = 1'b0;
        #1;
        check("req_clear", {31'b0, bus.mem_rd_req}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        rdy             = 1'b1;
        bus.if_rd_en    = 1'b0;
        bus.if_rd_addr  = '0;
        bus.mem_rd_done = 1'b0;
        bus.mem_rd_data = '0;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        bus.if_rd_en = 1'b1;
        #1;
        check("rst_req", {31'b0, bus.mem_rd_req}, 32'd0);
        check("rst_addr", bus.mem_rd_addr, 32'd0);
        check("rst_hit", {31'b0, bus.if_hit}, 32'd0);
        bus.if_rd_en = 1'b0;
        rst = 1'b0;
        cyc();

        // ---------------- cold miss at 0x0, 2-cycle memory ----------------
        line_words[0] = 32'h0000_0013;
        line_words[1] = 32'h0010_0093;
        line_words[2] = 32'h0020_0113;
        line_words[3] = 32'h0030_0193;
        lookup(32'h0, 1'b0, 32'h0);
        refill(32'h0, 2, 32'h0);
        lookup(32'h8, 1'b1, 32'h0020_0113);
        cyc();

        // ---------------- table of lookups on filled line 0 ----------------
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0010_0093, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0030_0193, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0,         1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0020_0113, 1'b0};
        for (int i = 0; i < 8; i++) begin
            rdy            = vecs[i].rdy;
            bus.if_rd_en   = vecs[i].en;
            bus.if_rd_addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_hit", i), {31'b0, bus.if_hit}, {31'b0, vecs[i].exp_hit});
            if (vecs[i].exp_hit) begin
                check($sformatf("vec%0d_inst", i), bus.if_hit_inst, vecs[i].exp_inst);
            end
            check($sformatf("vec%0d_req", i), {31'b0, bus.mem_rd_req}, {31'b0, vecs[i].exp_req});
            cyc();
        end
        rdy          = 1'b1;
        bus.if_rd_en = 1'b0;
        #1;
        check("table_no_req", {31'b0, bus.mem_rd_req}, 32'd0);
        cyc();

        // ---------------- conflict on index 0 ----------------
        lookup(32'h400, 1'b0, 32'h0);
        line_words[0] = 32'hA000_0000;
        line_words[1] = 32'hA000_0001;
        line_words[2] = 32'hA000_0002;
        line_words[3] = 32'hA000_0003;
        refill(32'h400, 1, 32'h400);
        lookup(32'h404, 1'b1, 32'hA000_0001);
        cyc();
        lookup(32'h0, 1'b0, 32'h0);
        line_words[0] = 32'h0000_0013;
        line_words[1] = 32'h0010_0093;
        line_words[2] = 32'h0020_0113;
        line_words[3] = 32'h0030_0193;
        // 0x20 is probed while line 0 fills: must not hit
        refill(32'h0, 3, 32'h20);
        lookup(32'hC, 1'b1, 32'h0030_0193);
        cyc();
        lookup(32'h400, 1'b0, 32'h0);
        bus.if_rd_en = 1'b0;
        cyc();

        // ---------------- reset during refill ----------------
        lookup(32'h10, 1'b0, 32'h0);
        cyc();
        bus.if_rd_en    = 1'b0;
        bus.mem_rd_done = 1'b1;
        bus.mem_rd_data = 32'hC0C0_0000;
        #1;
        check("rr_addr0", bus.mem_rd_addr, 32'h10);
        cyc();
        bus.mem_rd_data = 32'hC0C0_0001;
        #1;
        check("rr_addr1", bus.mem_rd_addr, 32'h14);
        cyc();
        bus.mem_rd_done = 1'b0;
        rst             = 1'b1;
        cyc();
        #1;
        check("rr_req_after_rst", {31'b0, bus.mem_rd_req}, 32'd0);
        check("rr_addr_after_rst", bus.mem_rd_addr, 32'd0);
        rst = 1'b0;
        cyc();
        lookup(32'h0, 1'b0, 32'h0);
        line_words[0] = 32'hB000_0000;
        line_words[1] = 32'hB000_0001;
        line_words[2] = 32'hB000_0002;
        line_words[3] = 32'hB000_0003;
        refill(32'h0, 1, 32'h0);
        lookup(32'h4, 1'b1, 32'hB000_0001);
        cyc();
        lookup(32'h10, 1'b0, 32'h0);
        line_words[0] = 32'hC000_0000;
        line_words[1] = 32'hC000_0001;
        line_words[2] = 32'hC000_0002;
        line_words[3] = 32'hC000_0003;
        refill(32'h10, 2, 32'h14);
        lookup(32'h14, 1'b1, 32'hC000_0001);
        cyc();

        // ---------------- rdy stall during refill of 0x20 ----------------
        lookup(32'h20, 1'b0, 32'h0);
        line_words[0] = 32'hD000_0000;
        line_words[1] = 32'hD000_0001;
        line_words[2] = 32'hD000_0002;
        line_words[3] = 32'hD000_0003;
        cyc();
        bus.if_rd_en    = 1'b0;
        bus.mem_rd_done = 1'b1;
        bus.mem_rd_data = line_words[0];
        #1;
        check("st_addr0", bus.mem_rd_addr, 32'h20);
        cyc();
        rdy             = 1'b0;
        bus.mem_rd_data = 32'hBAD0_0000;
        bus.if_rd_en    = 1'b1;
        bus.if_rd_addr  = 32'h4;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("st_req", {31'b0, bus.mem_rd_req}, 32'd1);
            check("st_addr", bus.mem_rd_addr, 32'h24);
            check("st_hit", {31'b0, bus.if_hit}, 32'd0);
            cyc();
        end
        rdy             = 1'b1;
        bus.mem_rd_done = 1'b0;
        bus.if_rd_en    = 1'b0;
        #1;
        check("st_resume_addr", bus.mem_rd_addr, 32'h24);
        cyc();
        for (int k = 1; k < 4; k++) begin
            bus.mem_rd_done = 1'b1;
            bus.mem_rd_data = line_words[k];
            #1;
            check("st_word_addr", bus.mem_rd_addr, 32'h20 + 32'(4 * k));
            cyc();
        end
        bus.mem_rd_done = 1'b0;
        #1;
        check("st_req_clear", {31'b0, bus.mem_rd_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            lookup(32'h20 + 32'(4 * k), 1'b1, line_words[k]);
            cyc();
        end
        lookup(32'h4, 1'b1, 32'hB000_0001);
        cyc();

        // ---------------- stray done while idle ----------------
        bus.if_rd_en    = 1'b0;
        bus.mem_rd_done = 1'b1;
        bus.mem_rd_data = 32'hEEEE_EEEE;
        cyc();
        bus.mem_rd_done = 1'b0;
        #1;
        check("idle_done_req", {31'b0, bus.mem_rd_req}, 32'd0);
        lookup(32'h0, 1'b1, 32'hB000_0000);
        lookup(32'h2C, 1'b1, 32'hD000_0003);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache; the responder side of the fetcher's cache lookup interface.
- Serves the instruction word at the requested PC combinationally on a hit.
- On a miss, refills the whole line word-by-word through a request/done handshake with the memory controller.
- Sits between the instruction fetch unit and the memory controller's instruction read port.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines).
- LINE_WORDS_LOG, 2, log2 of 32-bit words per line (4 words = 16 bytes).
- Derived (not overridable): OFF_BITS = 2+LINE_WORDS_LOG; TAG_BITS = 32-INDEX_BITS-OFF_BITS; addr[OFF_BITS-1:2] = word select, addr[OFF_BITS+INDEX_BITS-1:OFF_BITS] = index, addr[31:OFF_BITS+INDEX_BITS] = tag.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- if_rd_en  in  1  fetcher lookup valid
- if_rd_addr  in  32  lookup PC, word-aligned
- if_hit  out  1  combinational: lookup hit this cycle
- if_hit_inst  out  32  combinational: instruction word at if_rd_addr, valid when if_hit
- mem_rd_req  out  1  registered refill word request, held until done
- mem_rd_addr  out  32  registered word address of current refill request
- mem_rd_done  in  1  one-cycle pulse: mem_rd_data valid, request consumed
- mem_rd_data  in  32  returned word

Behaviour:
- Storage: valid[2^INDEX_BITS], tag array, data array of 2^INDEX_BITS x 2^LINE_WORDS_LOG words. Only valid bits are reset.
- if_hit = !rst && rdy && if_rd_en && state==IDLE && valid[idx] && tag[idx]==addr tag.
- if_hit_inst = data[idx][word]; value is don't-care when if_hit=0.
- Reset: state=IDLE, all valid=0, mem_rd_req=0, mem_rd_addr=0, refill counter=0. Reset mid-refill abandons the refill; the partially written line stays invalid.
- rdy=0: no state, array, counter or output-register update; mem_rd_done ignored; if_hit=0.
- FSM IDLE:
  - if_rd_en=1 and miss: latch line base = {if_rd_addr[31:OFF_BITS], OFF_BITS'b0}.
  - Next cycle: mem_rd_req=1, mem_rd_addr=base, cnt=0, state=REFILL.
  - if_rd_en=0 or hit: stay in IDLE, no memory traffic.
- FSM REFILL:
  - if_hit=0 for every address, including addresses in the line being filled.
  - mem_rd_req and mem_rd_addr held stable until mem_rd_done.
  - On mem_rd_done: write mem_rd_data to data[line idx][cnt].
    - If cnt != 2^LINE_WORDS_LOG-1: cnt+1, mem_rd_addr+4, mem_rd_req stays 1 with no bubble.
    - If cnt == last: write tag, valid[idx]=1, mem_rd_req=0, state=IDLE.
- The valid/tag write takes effect at the clock edge, so a lookup of that line hits in the first IDLE cycle.
- A refill always completes; a fetcher rollback or address change does not cancel it. The new address gets its own lookup afterward.
- Replacement: direct-mapped overwrite. The old line's valid bit is cleared when the refill starts, so a later lookup never hits on mixed data.
- mem_rd_done while IDLE: ignored.
- Miss penalty = 1 (issue) + sum of per-word memory latencies; the next lookup of the line hits in the IDLE cycle after the last done.
- No write port; self-modifying code is unsupported.

Test Plan:
- Cold miss at 0x0000_0000 with 2-cycle memory returning 0x00000013, 0x00100093, 0x00200113, 0x00300193 -> mem_rd_addr 0x0, 0x4, 0x8, 0xC in order, req held between dones. The cycle after the last done, lookup 0x8 gives if_hit=1, if_hit_inst=0x00200113.
- Line 0 filled, lookups 0x0, 0x4, 0xC on consecutive cycles -> if_hit=1 each cycle, matching words, mem_rd_req stays 0.
- Conflict: lookup 0x400 (index 0, tag 1) -> refill of 0x400..0x40C. Then lookup 0x0 -> miss and refill from 0x0.
- Reset asserted after 2 of 4 dones -> next cycle mem_rd_req=0. Lookup 0x0 after reset -> miss, refill restarts at 0x0.
- rdy=0 for 3 cycles in REFILL with mem_rd_done pulsed during the stall -> cnt, mem_rd_addr and data unchanged. The refill resumes when rdy=1 and the line completes correctly.
- if_rd_en=0 with a missing address present, then a lookup of 0x20 during REFILL of line 0 -> no new request in the first case, if_hit=0 in the second. After refill, 0x20 is fetched separately.
